// File: rtl/bcd_alu_sequencer.sv
// Keypad-driven sequencer for a 3-digit BCD calculator.
// It collects operands and an operator, hands them to an external BCD ALU, and drives the display.
module bcd_alu_sequencer #(
    parameter int ALU_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [11:0] alu_a,
    output logic [11:0] alu_b,
    input  logic        alu_done,
    input  logic [11:0] alu_result,
    input  logic        alu_ovf,
    output logic [11:0] disp_value,
    output logic [1:0]  disp_sel,
    output logic        busy,
    output logic        error
);

    localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    typedef enum logic [2:0] {ENTER_A, ENTER_B, WAIT, SHOW, ERR} stateType;

    stateType         state, stateNext;
    logic [11:0]      regA, regB, regR;
    logic [1:0]       regOp, cntA, cntB;
    logic [CNT_W-1:0] timeoutCnt;
    logic [11:0]      dispValue, dispHoldValue;
    logic [1:0]       dispSel, dispHoldSel;

    logic isDigit, isOp, isEquals, isClear, timedOut;
    logic [1:0] keyOp;

    assign isDigit  = key_valid && (key_code <= 4'd9);
    assign isOp     = key_valid && (key_code >= 4'd10) && (key_code <= 4'd12);
    assign isEquals = key_valid && (key_code == 4'd13);
    assign isClear  = key_valid && (key_code == 4'd14);
    assign timedOut = (timeoutCnt == TIMEOUT_LAST);
    // ADD/SUB/MUL key codes 10/11/12 map onto ALU op codes 00/01/10.
    assign keyOp    = key_code[1:0] - 2'd2;

    // State register, with busy/error registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ENTER_A;
            busy  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= stateNext;
            busy  <= (stateNext == WAIT);
            error <= (stateNext == ERR);
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext = state;
        if (isClear) begin
            stateNext = ENTER_A;
        end else begin
            case (state)
                ENTER_A: if (isOp) stateNext = ENTER_B;
                ENTER_B: if (isEquals) stateNext = WAIT;
                WAIT: begin
                    if (alu_done)      stateNext = alu_ovf ? ERR : SHOW;
                    else if (timedOut) stateNext = ERR;
                end
                SHOW: begin
                    if (isDigit)   stateNext = ENTER_A;
                    else if (isOp) stateNext = ENTER_B;
                end
                default: stateNext = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || isClear) begin
            regA       <= '0;
            regB       <= '0;
            regR       <= '0;
            regOp      <= '0;
            cntA       <= '0;
            cntB       <= '0;
            timeoutCnt <= '0;
            alu_start  <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                ENTER_A: begin
                    if (isDigit && cntA != 2'd3) begin
                        regA <= {regA[7:0], key_code};
                        cntA <= cntA + 2'd1;
                    end else if (isOp) begin
                        regOp <= keyOp;
                        regB  <= '0;
                        cntB  <= '0;
                    end
                end
                ENTER_B: begin
                    if (isDigit && cntB != 2'd3) begin
                        regB <= {regB[7:0], key_code};
                        cntB <= cntB + 2'd1;
                    end else if (isOp) begin
                        regOp <= keyOp;
                    end else if (isEquals) begin
                        alu_start  <= 1'b1;
                        timeoutCnt <= '0;
                    end
                end
                WAIT: begin
                    timeoutCnt <= timeoutCnt + 1'b1;
                    if (alu_done && !alu_ovf) regR <= alu_result;
                end
                SHOW: begin
                    if (isDigit) begin
                        regA <= {8'h000, key_code};
                        cntA <= 2'd1;
                    end else if (isOp) begin
                        regA  <= regR;
                        cntA  <= 2'd3;
                        regOp <= keyOp;
                        regB  <= '0;
                        cntB  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The display freezes during WAIT, so remember what was shown on the way in.
    always_ff @(posedge clk) begin
        if (reset) begin
            dispHoldValue <= '0;
            dispHoldSel   <= '0;
        end else if (state != WAIT) begin
            dispHoldValue <= dispValue;
            dispHoldSel   <= dispSel;
        end
    end

    always_comb begin
        dispValue = dispHoldValue;
        dispSel   = dispHoldSel;
        case (state)
            ENTER_A: begin
                dispValue = regA;
                dispSel   = 2'b00;
            end
            ENTER_B: begin
                dispValue = (cntB != 2'd0) ? regB : regA;
                dispSel   = (cntB != 2'd0) ? 2'b01 : 2'b00;
            end
            SHOW: begin
                dispValue = regR;
                dispSel   = 2'b10;
            end
            ERR: begin
                dispValue = 12'hEEE;
                dispSel   = 2'b11;
            end
            default: ;
        endcase
    end

    assign alu_a      = regA;
    assign alu_b      = regB;
    assign alu_op     = regOp;
    assign disp_value = dispValue;
    assign disp_sel   = dispSel;

endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Scoreboard bench for bcd_alu_sequencer: stimulus queues expected ALU requests and
// post-WAIT display results, and a monitor checks them as the DUT presents them.
module tb_bcd_alu_sequencer;

    localparam int TO = 16;
    localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12,
                           K_EQ = 4'd13, K_CLR = 4'd14, K_RSV = 4'd15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = '0;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [11:0] alu_a, alu_b;
    logic        alu_done = 1'b0;
    logic [11:0] alu_result = '0;
    logic        alu_ovf = 1'b0;
    logic [11:0] disp_value;
    logic [1:0]  disp_sel;
    logic        busy, error;

    int passCnt = 0;
    int totalCnt = 0;

    logic [25:0] startQ[$];   // {alu_op, alu_a, alu_b} per expected alu_start pulse
    logic [14:0] doneQ[$];    // {error, disp_sel, disp_value} when busy falls

    bcd_alu_sequencer #(.ALU_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
        .disp_value(disp_value), .disp_sel(disp_sel), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic aluDone(input logic [11:0] res, input logic ovf);
        alu_done   = 1'b1;
        alu_result = res;
        alu_ovf    = ovf;
        tick();
        alu_done = 1'b0;
        alu_ovf  = 1'b0;
    endtask

    task automatic checkDisp(input string name, input logic [1:0] sel, input logic [11:0] val);
        check(name, {18'h0, disp_sel, disp_value}, {18'h0, sel, val});
    endtask

    // Monitor: compares ALU requests and WAIT exits against the scoreboard queues.
    logic prevBusy = 1'b0;
    always @(negedge clk) begin
        if (alu_start === 1'b1) begin
            if (startQ.size() == 0) check("start_unexpected", 32'd1, 32'd0);
            else check("alu_request", {6'h0, alu_op, alu_a, alu_b}, {6'h0, startQ.pop_front()});
        end
        if (prevBusy && busy === 1'b0) begin
            if (doneQ.size() == 0) check("wait_exit_unexpected", 32'd1, 32'd0);
            else check("wait_exit", {17'h0, error, disp_sel, disp_value}, {17'h0, doneQ.pop_front()});
        end
        prevBusy = (busy === 1'b1);
    end

    initial begin
        int n;
        // Reset held with a key and alu_done asserted: reset wins.
        key_valid = 1'b1; key_code = 4'd5; alu_done = 1'b1; alu_result = 12'h999;
        tick(); tick();
        reset = 1'b0; key_valid = 1'b0; alu_done = 1'b0;
        check("rst_start", {31'h0, alu_start}, 32'd0);
        check("rst_op_a_b", {6'h0, alu_op, alu_a, alu_b}, 32'd0);
        checkDisp("rst_disp", 2'b00, 12'h000);
        check("rst_busy_err", {30'h0, busy, error}, 32'd0);

        // 123 + 45 = 168
        press(4'd1); press(4'd2); press(4'd3);
        checkDisp("entry_a", 2'b00, 12'h123);
        press(K_ADD);
        checkDisp("op_shows_a", 2'b00, 12'h123);
        press(4'd4); press(4'd5);
        checkDisp("entry_b", 2'b01, 12'h045);
        startQ.push_back({2'b00, 12'h123, 12'h045});
        press(K_EQ);
        check("busy_in_wait", {31'h0, busy}, 32'd1);
        checkDisp("wait_holds", 2'b01, 12'h045);
        tick();
        check("start_one_cycle", {31'h0, alu_start}, 32'd0);
        doneQ.push_back({1'b0, 2'b10, 12'h168});
        aluDone(12'h168, 1'b0);
        checkDisp("show_r", 2'b10, 12'h168);
        press(K_EQ);
        checkDisp("show_eq_ignored", 2'b10, 12'h168);

        // Chaining from SHOW: 168 + 2 with overflow -> ERR
        press(K_ADD);
        checkDisp("chain_a", 2'b00, 12'h168);
        press(4'd2);
        startQ.push_back({2'b00, 12'h168, 12'h002});
        press(K_EQ);
        doneQ.push_back({1'b1, 2'b11, 12'hEEE});
        tick();
        aluDone(12'h170, 1'b1);
        check("ovf_error", {31'h0, error}, 32'd1);
        press(4'd7);
        checkDisp("err_digit_ignored", 2'b11, 12'hEEE);
        press(K_CLR);
        check("clr_from_err", {13'h0, error, disp_sel, disp_value, alu_op}, 32'd0);
        check("clr_regs", {8'h0, alu_a, alu_b}, 32'd0);

        // 4th digit ignored, EQUALS/15 ignored in ENTER_A, op replacement
        press(K_EQ);
        check("eq_in_a_ignored", {31'h0, busy}, 32'd0);
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        checkDisp("fourth_digit", 2'b00, 12'h987);
        press(K_RSV);
        checkDisp("key15_ignored", 2'b00, 12'h987);
        press(K_SUB); press(K_MUL);
        check("op_replaced_mul", {30'h0, alu_op}, 32'd2);
        checkDisp("enter_b_shows_a", 2'b00, 12'h987);
        press(K_SUB);
        press(4'd1); press(4'd2);
        startQ.push_back({2'b01, 12'h987, 12'h012});
        press(K_EQ);
        // alu_done and a digit key in the same WAIT cycle
        doneQ.push_back({1'b0, 2'b10, 12'h975});
        key_valid = 1'b1; key_code = 4'd5;
        aluDone(12'h975, 1'b0);
        key_valid = 1'b0;
        checkDisp("done_beats_key", 2'b10, 12'h975);
        check("a_unchanged", {20'h0, alu_a}, 32'h987);

        // Timeout: 2 + 3 with no alu_done
        press(4'd2);
        checkDisp("show_digit_to_a", 2'b00, 12'h002);
        press(K_ADD); press(4'd3);
        startQ.push_back({2'b00, 12'h002, 12'h003});
        doneQ.push_back({1'b1, 2'b11, 12'hEEE});
        press(K_EQ);
        n = 0;
        while (error !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 32'd16);
        aluDone(12'h005, 1'b0);
        checkDisp("late_done_in_err", 2'b11, 12'hEEE);

        // CLEAR during WAIT, stale alu_done 3 cycles later
        press(K_CLR);
        press(4'd7); press(K_ADD); press(4'd8);
        startQ.push_back({2'b00, 12'h007, 12'h008});
        press(K_EQ);
        doneQ.push_back({1'b0, 2'b00, 12'h000});
        press(K_CLR);
        tick(); tick();
        aluDone(12'h015, 1'b0);
        check("abort_state", {29'h0, busy, error, disp_sel == 2'b10}, 32'd0);
        checkDisp("abort_disp", 2'b00, 12'h000);

        // Reset during WAIT, then a late alu_done
        press(4'd3); press(K_ADD); press(4'd4);
        startQ.push_back({2'b00, 12'h003, 12'h004});
        press(K_EQ);
        doneQ.push_back({1'b0, 2'b00, 12'h000});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        aluDone(12'h007, 1'b0);
        checkDisp("rst_wait_disp", 2'b00, 12'h000);
        check("rst_wait_busy", {31'h0, busy}, 32'd0);

        tick(); tick();
        check("start_queue_empty", startQ.size(), 32'd0);
        check("done_queue_empty", doneQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/bcd_alu_sequencer.md
BCD_ALU_SEQUENCER -- requirements
Module: bcd_alu_sequencer

Interface
REQ-001 Parameter ALU_TIMEOUT, default 1024, is the maximum number of cycles to wait for alu_done after alu_start.
REQ-002 clk  input  1  system clock; all logic is on the rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 key_valid  input  1  one-cycle strobe marking a debounced keypad event.
REQ-005 key_code  input  4  key code: 0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 EQUALS, 14 CLEAR, 15 reserved.
REQ-006 alu_start  output  1  one-cycle request pulse to the BCD ALU.
REQ-007 alu_op  output  2  00 ADD, 01 SUB, 10 MUL.
REQ-008 alu_a, alu_b  output  12 each  3-digit BCD operands.
REQ-009 alu_done  input  1  one-cycle completion strobe from the ALU.
REQ-010 alu_result  input  12  3-digit BCD result, valid when alu_done=1.
REQ-011 alu_ovf  input  1  overflow or negative flag, valid when alu_done=1.
REQ-012 disp_value  output  12  BCD value for the display.
REQ-013 disp_sel  output  2  source of disp_value: 00 A, 01 B, 10 result, 11 error.
REQ-014 busy  output  1  high while in WAIT.
REQ-015 error  output  1  high while in ERR.

Function
REQ-016 The block SHALL implement the states ENTER_A, ENTER_B, WAIT, SHOW, and ERR.
REQ-017 A digit key in ENTER_A SHALL perform A <= {A[7:0], digit} and increment the A digit count; a 4th or later digit SHALL be ignored.
REQ-018 Digit entry into B in ENTER_B SHALL follow the same rule as REQ-017, with its own digit count.
REQ-019 An operator key (10-12) in ENTER_A SHALL latch op, clear B and its digit count, and move to ENTER_B.
REQ-020 An operator key in ENTER_B SHALL replace the latched op, keep B, and stay in ENTER_B.
REQ-021 EQUALS in ENTER_A SHALL be ignored.
REQ-022 EQUALS in ENTER_B SHALL assert alu_start for exactly one cycle, clear the timeout counter, and move to WAIT on the next edge.
REQ-023 alu_a, alu_b, and alu_op SHALL be driven from the A, B, and op registers, held stable from the alu_start cycle through the alu_done cycle.
REQ-024 In WAIT, all keys except CLEAR SHALL be dropped, not queued.
REQ-025 In WAIT, the timeout counter SHALL increment every cycle.
REQ-026 In WAIT, alu_done with alu_ovf=0 SHALL latch alu_result into R and move to SHOW.
REQ-027 In WAIT, alu_done with alu_ovf=1 SHALL move to ERR.
REQ-028 In WAIT, the counter reaching ALU_TIMEOUT-1 without alu_done SHALL move to ERR.
REQ-029 If alu_done and the timeout occur in the same cycle, alu_done SHALL take precedence.
REQ-030 alu_done outside WAIT SHALL be ignored, including a late strobe from an aborted operation.
REQ-031 In SHOW, a digit key SHALL clear A, load the digit as A's first digit, and move to ENTER_A.
REQ-032 In SHOW, an operator key SHALL copy R into A with digit count 3, latch op, clear B, and move to ENTER_B (chaining).
REQ-033 In SHOW, EQUALS SHALL be ignored.
REQ-034 In ERR, every key except CLEAR SHALL be ignored.
REQ-035 CLEAR in any state, including WAIT, SHALL zero A, B, R, op, and digit counts, and move to ENTER_A; in WAIT this abandons the pending ALU operation.
REQ-036 key_code 15 SHALL be ignored in every state.
REQ-037 In ENTER_A, disp_value SHALL be A and disp_sel SHALL be 00.
REQ-038 In ENTER_B, disp_value SHALL be B with disp_sel 01 if the B digit count is nonzero; otherwise disp_value SHALL be A with disp_sel 00.
REQ-039 In WAIT, disp_value and disp_sel SHALL hold their previous values.
REQ-040 In SHOW, disp_value SHALL be R and disp_sel SHALL be 10.
REQ-041 In ERR, disp_value SHALL be 0xEEE and disp_sel SHALL be 11.
REQ-042 busy and error SHALL be registered decodes of the state.

Reset
REQ-043 While reset=1 at a clock edge, the state SHALL become ENTER_A and A, B, R, op, digit counts, and the timeout counter SHALL clear.
REQ-044 After that edge, alu_start=0, alu_op=00, alu_a=alu_b=0x000, disp_value=0x000, disp_sel=00, busy=0, and error=0.
REQ-045 Reset SHALL take precedence over key_valid and alu_done in the same cycle.
REQ-046 Reset during WAIT SHALL abandon the operation, and a later alu_done SHALL be ignored.

Verification
REQ-047 Keys 1,2,3,ADD,4,5,EQUALS, then alu_done with result 0x168, ovf=0 -> one alu_start pulse with alu_a=0x123, alu_b=0x045, alu_op=00; then SHOW with disp_value=0x168, disp_sel=10.
REQ-048 Keys 9,8,7,6 -> A=0x987, 4th digit ignored; then SUB,MUL -> op=10 and state ENTER_B with disp_value=0x987.
REQ-049 EQUALS with alu_done never arriving (ALU_TIMEOUT=16) -> ERR after 16 cycles in WAIT with error=1 and disp_value=0xEEE; a digit key leaves it in ERR; CLEAR -> ENTER_A with all registers 0.
REQ-050 CLEAR during WAIT, then alu_done 3 cycles later -> ENTER_A, R stays 0x000, no state change on the alu_done.
REQ-051 From SHOW with R=0x168, keys ADD,2,EQUALS -> alu_a=0x168, alu_b=0x002; alu_done with ovf=1 -> ERR.
REQ-052 alu_done and key_valid (digit 5) in the same WAIT cycle -> SHOW, digit dropped, A unchanged.
